// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader
// Writes a length/checksum framed byte stream into the CPU instruction memory,
// holding the CPU in reset while loading. Define IMEM_LOADER_FILL_EN to pad
// unwritten words with FILL_WORD after a good short load.
// Rev    : 1.0
// ============================================================================
module imem_loader #(
  parameter int              ADDR_W    = 4,
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 16,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'hB0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    FILL = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [5:0]        c_depth = 6'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  state_t              r_state, w_state_next;
  logic [7:0]          r_csum, w_csum_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [4:0]          r_rem, w_rem_next;
  logic                r_mem_we, w_we_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_waddr_next;
  logic [DATA_W-1:0]   r_mem_wdata, w_wdata_next;
  logic                w_in_ready;
  logic                w_xfer;
  logic [4:0]          w_len;
  logic                w_len_ok;

  assign w_in_ready = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  assign w_xfer     = in_valid && w_in_ready;
  assign w_len      = in_data[4:0];
  assign w_len_ok   = (w_len != 5'd0) && ({1'b0, w_len} <= c_depth);

`ifndef IMEM_LOADER_FILL_EN
  logic w_unused_fill;
  assign w_unused_fill = ^FILL_WORD;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_csum      <= '0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_csum      <= w_csum_next;
      r_addr      <= w_addr_next;
      r_rem       <= w_rem_next;
      r_mem_we    <= w_we_next;
      r_mem_addr  <= w_waddr_next;
      r_mem_wdata <= w_wdata_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_csum_next  = r_csum;
    w_addr_next  = r_addr;
    w_rem_next   = r_rem;
    w_we_next    = 1'b0;
    w_waddr_next = r_mem_addr;
    w_wdata_next = r_mem_wdata;

    case (r_state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          w_state_next = LEN;
          w_csum_next  = '0;
          w_addr_next  = '0;
          w_rem_next   = '0;
        end else if (r_state == DONE) begin
          w_state_next = IDLE;
        end
      end
      LEN: begin
        if (w_xfer) begin
          if (w_len_ok) begin
            w_csum_next  = r_csum ^ in_data;
            w_rem_next   = w_len;
            w_state_next = DATA;
          end else begin
            w_state_next = ERR;
          end
        end
      end
      DATA: begin
        if (w_xfer) begin
          w_we_next    = 1'b1;
          w_waddr_next = r_addr;
          w_wdata_next = DATA_W'(in_data);
          w_csum_next  = r_csum ^ in_data;
          w_addr_next  = r_addr + ADDR_W'(1);
          w_rem_next   = r_rem - 5'd1;
          if (r_rem == 5'd1)
            w_state_next = CSUM;
        end
      end
      CSUM: begin
        if (w_xfer) begin
          if (in_data == r_csum) begin
`ifdef IMEM_LOADER_FILL_EN
            // A full-depth load wraps the address back to 0; nothing to pad.
            w_state_next = (r_addr != '0) ? FILL : DONE;
`else
            w_state_next = DONE;
`endif
          end else begin
            w_state_next = ERR;
          end
        end
      end
`ifdef IMEM_LOADER_FILL_EN
      FILL: begin
        w_we_next    = 1'b1;
        w_waddr_next = r_addr;
        w_wdata_next = FILL_WORD;
        w_addr_next  = r_addr + ADDR_W'(1);
        if (r_addr == c_last)
          w_state_next = DONE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready   = w_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  // The CPU stays held through ERR because memory may already be partly overwritten.
  assign cpu_hold   = (r_state != IDLE) && (r_state != DONE);
  assign load_done  = (r_state == DONE);
  assign load_error = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, cpu_hold, load_done, load_error;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

`ifdef IMEM_LOADER_FILL_EN
  localparam int FILL_ON = 1;
`else
  localparam int FILL_ON = 0;
`endif

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;
  int wr_cnt = 0;

  always @(negedge clk) if (mem_we === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Called right after the checksum byte was accepted; steps through any fill and DONE.
  task automatic complete_load(input int n);
    logic [13:0] exp;
    if (FILL_ON == 1 && n < 16) begin
      for (int k = n; k < 16; k++) begin
        tick();
        exp = {1'b1, 4'(k), 8'hB0, (k == 15)};
        total_n++;
        if ({mem_we, mem_addr, mem_wdata, load_done} !== exp)
          $display("FAIL fill_k%0d: got %h want %h", k, {mem_we, mem_addr, mem_wdata, load_done}, exp);
        else pass_n++;
      end
    end
    total_n++;
    if ({load_done, cpu_hold, load_error} !== 3'b100)
      $display("FAIL done_flags: done/hold/err got %b want 100", {load_done, cpu_hold, load_error});
    else pass_n++;
    tick();
    total_n++;
    if ({load_done, cpu_hold, in_ready, mem_we} !== 4'b0000)
      $display("FAIL after_done: done/hold/rdy/we got %b want 0000", {load_done, cpu_hold, in_ready, mem_we});
    else pass_n++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    total_n++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error} !== 17'h0)
      $display("FAIL reset_vals: got %h want 0", {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error});
    else pass_n++;
    reset = 1'b0;
    tick();
    total_n++;
    if ({in_ready, cpu_hold, mem_we} !== 3'b000)
      $display("FAIL idle_after_reset: got %b want 000", {in_ready, cpu_hold, mem_we});
    else pass_n++;
  endtask

  task automatic test_good_load();
    logic [7:0] d [3] = '{8'h1A, 8'h23, 8'h30};
    int w0 = wr_cnt;
    pulse_start();
    total_n++;
    if ({cpu_hold, load_error, in_ready} !== 3'b101)
      $display("FAIL start_flags: hold/err/rdy got %b want 101", {cpu_hold, load_error, in_ready});
    else pass_n++;
    send_byte(8'h03);
    total_n++;
    if (mem_we !== 1'b0) $display("FAIL len_no_write: mem_we got %b want 0", mem_we);
    else pass_n++;
    for (int i = 0; i < 3; i++) begin
      send_byte(d[i]);
      total_n++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'(i), d[i]})
        $display("FAIL good_wr%0d: got %h want %h", i, {mem_we, mem_addr, mem_wdata}, {1'b1, 4'(i), d[i]});
      else pass_n++;
    end
    send_byte(8'h0A);
    complete_load(3);
    total_n++;
    if (wr_cnt - w0 !== (FILL_ON == 1 ? 16 : 3))
      $display("FAIL good_wr_count: got %0d want %0d", wr_cnt - w0, (FILL_ON == 1 ? 16 : 3));
    else pass_n++;
  endtask

  task automatic test_bad_csum();
    int seen_done = 0;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h1A);
    send_byte(8'h23);
    send_byte(8'h30);
    send_byte(8'hFF);
    total_n++;
    if ({load_error, cpu_hold, in_ready, load_done} !== 4'b1100)
      $display("FAIL bad_csum_flags: err/hold/rdy/done got %b want 1100", {load_error, cpu_hold, in_ready, load_done});
    else pass_n++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done === 1'b1) seen_done++;
    end
    total_n++;
    if ({load_error, cpu_hold, seen_done != 0} !== 3'b110)
      $display("FAIL err_sticky: err/hold/done_seen got %b want 110", {load_error, cpu_hold, seen_done != 0});
    else pass_n++;
    pulse_start();
    total_n++;
    if ({load_error, cpu_hold} !== 2'b01)
      $display("FAIL recover_start: err/hold got %b want 01", {load_error, cpu_hold});
    else pass_n++;
    send_byte(8'h01);
    send_byte(8'h55);
    total_n++;
    if ({mem_we, mem_addr, mem_wdata} !== 13'h1055)
      $display("FAIL recover_wr: got %h want 1055", {mem_we, mem_addr, mem_wdata});
    else pass_n++;
    send_byte(8'h54);
    complete_load(1);
  endtask

  task automatic test_bad_len();
    logic [7:0] lens [2] = '{8'h00, 8'h11};
    for (int j = 0; j < 2; j++) begin
      int w0 = wr_cnt;
      pulse_start();
      send_byte(lens[j]);
      total_n++;
      if ({in_ready, load_error, cpu_hold, mem_we} !== 4'b0110)
        $display("FAIL bad_len_%h: rdy/err/hold/we got %b want 0110", lens[j], {in_ready, load_error, cpu_hold, mem_we});
      else pass_n++;
      tick();
      total_n++;
      if (wr_cnt !== w0)
        $display("FAIL bad_len_%h_writes: got %0d want 0", lens[j], wr_cnt - w0);
      else pass_n++;
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] cs = 8'h10;
    logic [7:0] b;
    int w0 = wr_cnt;
    int bad = 0;
    pulse_start();
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      b = 8'h21 + 8'(i * 11);
      cs = cs ^ b;
      send_byte(b);
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'(i), b}) begin
        $display("FAIL full_wr%0d: got %h want %h", i, {mem_we, mem_addr, mem_wdata}, {1'b1, 4'(i), b});
        bad++;
      end
    end
    total_n++;
    if (bad == 0) pass_n++;
    send_byte(cs);
    total_n++;
    if ({mem_we, load_done} !== 2'b01)
      $display("FAIL full_no_17th: we/done got %b want 01", {mem_we, load_done});
    else pass_n++;
    complete_load(16);
    total_n++;
    if (wr_cnt - w0 !== 16) $display("FAIL full_wr_count: got %0d want 16", wr_cnt - w0);
    else pass_n++;
  endtask

  task automatic test_backpressure();
    logic [7:0] d [3] = '{8'h1A, 8'h23, 8'h30};
    pulse_start();
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      in_data    = d[i];
      load_start = (i == 1);
      tick();
      load_start = 1'b0;
      total_n++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'(i), d[i]})
        $display("FAIL bp_wr%0d: got %h want %h", i, {mem_we, mem_addr, mem_wdata}, {1'b1, 4'(i), d[i]});
      else pass_n++;
      in_valid = 1'b0;
      in_data  = 8'hEE;
      tick();
      total_n++;
      if ({mem_we, in_ready, cpu_hold} !== 3'b011)
        $display("FAIL bp_idle%0d: we/rdy/hold got %b want 011", i, {mem_we, in_ready, cpu_hold});
      else pass_n++;
    end
    send_byte(8'h0A);
    complete_load(3);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h1A);
    send_byte(8'h23);
    reset = 1'b1;
    #1;
    total_n++;
    if ({mem_we, cpu_hold, in_ready, load_done, load_error, mem_addr} !== 9'h0)
      $display("FAIL async_reset: got %h want 0", {mem_we, cpu_hold, in_ready, load_done, load_error, mem_addr});
    else pass_n++;
    #2;
    reset = 1'b0;
    tick();
    total_n++;
    if ({in_ready, cpu_hold} !== 2'b00)
      $display("FAIL post_reset_idle: rdy/hold got %b want 00", {in_ready, cpu_hold});
    else pass_n++;
    test_good_load();
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_bad_len();
    test_full_depth();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
`default_nettype wire
